// File: rtl/handshake_constant_buffered.sv
// Elastic constant source: each accepted control token yields one output token
// carrying VALUE, buffered in an occupancy counter so ready/valid are register-derived.
module handshake_constant_buffered #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] VALUE      = '0,
    parameter int                    DEPTH      = 2,
    parameter int                    CNT_WIDTH  = 16,
    localparam int                   OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [OCC_W-1:0]      occupancy,
    output logic [CNT_WIDTH-1:0]  tokens_issued
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("handshake_constant_buffered: DEPTH must be in 1..16");
    end

    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    logic [OCC_W-1:0]     r_cnt;
    logic [CNT_WIDTH-1:0] r_tokens;
    logic                 w_in_fire;
    logic                 w_out_fire;

    // Handshake flags come straight from the occupancy register, never from the
    // opposite channel, so the valid/ready chain is cut here.
    assign ctrl_ready = (r_cnt != FULL);
    assign outs_valid = (r_cnt != '0);
    assign outs       = VALUE;

    assign w_in_fire  = ctrl_valid & ctrl_ready;
    assign w_out_fire = outs_valid & outs_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_tokens <= '0;
        end else begin
            if (w_in_fire && !w_out_fire) begin
                r_cnt <= r_cnt + OCC_W'(1);
            end else if (w_out_fire && !w_in_fire) begin
                r_cnt <= r_cnt - OCC_W'(1);
            end
            if (w_out_fire) begin
                r_tokens <= r_tokens + CNT_WIDTH'(1);
            end
        end
    end

    assign occupancy     = r_cnt;
    assign tokens_issued = r_tokens;

endmodule

// File: tb/tb_handshake_constant_buffered.sv
// Directed bench for handshake_constant_buffered: three parameterisations
// (DEPTH 2 / 4 with 4-bit wrap counter / 1) driven from tables and short sequences.
module tb_handshake_constant_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=2, 19-bit constant
    logic        a_rst, a_cv, a_cr, a_ov, a_or;
    logic [18:0] a_outs;
    logic [1:0]  a_occ;
    logic [15:0] a_tok;

    // Instance B: DEPTH=4, 4-bit statistics counter
    logic        b_rst, b_cv, b_cr, b_ov, b_or;
    logic [7:0]  b_outs;
    logic [2:0]  b_occ;
    logic [3:0]  b_tok;

    // Instance C: DEPTH=1
    logic        c_rst, c_cv, c_cr, c_ov, c_or;
    logic [3:0]  c_outs;
    logic [0:0]  c_occ;
    logic [7:0]  c_tok;

    handshake_constant_buffered #(
        .DATA_WIDTH(19), .VALUE(19'h3EC22), .DEPTH(2), .CNT_WIDTH(16)
    ) dut_a (
        .clk(clk), .rst(a_rst), .ctrl_valid(a_cv), .ctrl_ready(a_cr),
        .outs(a_outs), .outs_valid(a_ov), .outs_ready(a_or),
        .occupancy(a_occ), .tokens_issued(a_tok)
    );

    handshake_constant_buffered #(
        .DATA_WIDTH(8), .VALUE(8'hA5), .DEPTH(4), .CNT_WIDTH(4)
    ) dut_b (
        .clk(clk), .rst(b_rst), .ctrl_valid(b_cv), .ctrl_ready(b_cr),
        .outs(b_outs), .outs_valid(b_ov), .outs_ready(b_or),
        .occupancy(b_occ), .tokens_issued(b_tok)
    );

    handshake_constant_buffered #(
        .DATA_WIDTH(4), .VALUE(4'h9), .DEPTH(1), .CNT_WIDTH(8)
    ) dut_c (
        .clk(clk), .rst(c_rst), .ctrl_valid(c_cv), .ctrl_ready(c_cr),
        .outs(c_outs), .outs_valid(c_ov), .outs_ready(c_or),
        .occupancy(c_occ), .tokens_issued(c_tok)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Row: inputs applied this cycle, plus outputs expected at the start of the cycle.
    typedef struct {
        logic       chk;
        logic       rst;
        logic       cv;
        logic       ordy;
        logic       ready;
        logic       valid;
        logic [2:0] occ;
        logic [3:0] tok;
    } vec_t;

    vec_t tbl[18];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires, acc, rdy_low, occ_bad;

        //            chk   rst   cv    ordy  ready valid occ   tok
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 4'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 4'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'd0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 4'd0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd4, 4'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 4'd1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3, 4'd2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 4'd3};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 4'd4};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 4'd5};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 4'd5};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 4'd5};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd3, 4'd5};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'd0};

        a_rst = 1'b1; a_cv = 1'b1; a_or = 1'b0;
        b_rst = 1'b1; b_cv = 1'b0; b_or = 1'b0;
        c_rst = 1'b1; c_cv = 1'b1; c_or = 1'b0;

        // Reset held two cycles (ctrl_valid asserted to show it is ignored)
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0; a_cv = 1'b0; c_rst = 1'b0; c_cv = 1'b0;
        check("rst_ready", a_cr, 1);
        check("rst_valid", a_ov, 0);
        check("rst_occ", a_occ, 0);
        check("rst_tok", a_tok, 0);
        check("rst_outs", a_outs, 32'h3EC22);

        // Single token: offered exactly one cycle after acceptance
        @(negedge clk);
        a_cv = 1'b1; a_or = 1'b1;
        check("single_pre_valid", a_ov, 0);
        @(negedge clk);
        a_cv = 1'b0;
        check("single_valid", a_ov, 1);
        check("single_occ", a_occ, 1);
        @(negedge clk);
        check("single_after_valid", a_ov, 0);
        check("single_tok", a_tok, 1);

        // Streaming 100 cycles at full throughput
        a_cv = 1'b1; a_or = 1'b1;
        fires = 0; rdy_low = 0; occ_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_ov && a_or) fires++;
            if (!a_cr) rdy_low++;
            if (i > 0 && a_occ != 2'd1) occ_bad++;
            @(negedge clk);
        end
        a_cv = 1'b0;
        check("stream_fires", fires, 99);
        check("stream_ready_low", rdy_low, 0);
        check("stream_occ_bad", occ_bad, 0);
        check("stream_tok", a_tok, 100);
        check("stream_occ_end", a_occ, 1);
        check("stream_outs", a_outs, 32'h3EC22);
        @(negedge clk);
        check("stream_drain_occ", a_occ, 0);
        check("stream_drain_tok", a_tok, 101);

        // Table: backpressure fill, full+simultaneous, drain, empty, mid-op reset
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_ready", i), b_cr, tbl[i].ready);
                check($sformatf("tbl%0d_valid", i), b_ov, tbl[i].valid);
                check($sformatf("tbl%0d_occ", i), b_occ, tbl[i].occ);
                check($sformatf("tbl%0d_tok", i), b_tok, tbl[i].tok);
                check($sformatf("tbl%0d_outs", i), b_outs, 32'hA5);
            end
            b_rst = tbl[i].rst; b_cv = tbl[i].cv; b_or = tbl[i].ordy;
            @(negedge clk);
        end

        // Wrap: 17 tokens through a 4-bit counter leave it at 1
        b_rst = 1'b1; b_cv = 1'b0; b_or = 1'b0;
        @(negedge clk);
        b_rst = 1'b0;
        acc = 0; fires = 0;
        for (int cyc = 0; cyc < 100 && fires < 17; cyc++) begin
            b_cv = (acc < 17);
            b_or = 1'b1;
            if (b_cv && b_cr) acc++;
            if (b_ov && b_or) fires++;
            @(negedge clk);
        end
        b_cv = 1'b0;
        check("wrap_fires", fires, 17);
        check("wrap_tok", b_tok, 1);
        check("wrap_occ", b_occ, 0);

        // DEPTH=1 alternates: 5 tokens in 10 cycles
        c_cv = 1'b1; c_or = 1'b1;
        fires = 0;
        for (int i = 0; i < 10; i++) begin
            if (c_ov && c_or) fires++;
            @(negedge clk);
        end
        c_cv = 1'b0;
        check("d1_fires", fires, 5);
        check("d1_tok", c_tok, 5);
        check("d1_outs", c_outs, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
